fft_frame_ctrl: RTL and testbench
=================================

// Module: fft_frame_ctrl
// PURPOSE
//  Parametrised framing/config controller for the run-time-configurable xfft core
//  (AXIS data-in, config and data-out channels). Sits between the audio sample stream
//  and the FFT in the analysis path. Counts handshaked samples only; generates in/out
//  tlast and bin index; sends run-time length/direction config; reconfigures only at
//  drained frame boundaries. Counts framing errors.
// PARAMETERS
//  DATA_W     24             real sample width; core data = {imag, real}, 2*DATA_W
//  MAX_LOG2N  10             max FFT length exponent (core built for 2**MAX_LOG2N)
//  SCALE_SCH  10'b1010101011 scaling schedule, MAX_LOG2N bits, sent in every config
//  ERR_W      8              error counter width (saturating)
// PORTS
//  clk              in   1            clock
//  reset            in   1            synchronous, active-high
//  cfg_log2n        in   4            requested length exponent, clamped to [3,MAX_LOG2N]
//  cfg_inverse      in   1            1 = inverse FFT, 0 = forward
//  din_data         in   DATA_W       real sample
//  din_valid        in   1            sample valid
//  din_ready        out  1            sample accepted when valid & ready
//  core_s_tdata     out  2*DATA_W     {DATA_W'0, din_data}
//  core_s_tvalid    out  1            din_valid & run gate
//  core_s_tready    in   1            core data-in ready
//  core_s_tlast     out  1            last sample of input frame
//  core_cfg_tdata   out  24           [4:0] log2n, [8] ~inverse, [8+MAX_LOG2N:9] SCALE_SCH, others 0
//  core_cfg_tvalid  out  1            config valid
//  core_cfg_tready  in   1            core config ready
//  core_m_tdata     in   2*DATA_W     core output bin
//  core_m_tvalid    in   1            core output valid
//  core_m_tlast     in   1            core output last
//  core_m_tready    out  1            = dout_ready
//  core_ev_err      in   1            OR of tlast_unexpected/tlast_missing events
//  dout_data        out  2*DATA_W     = core_m_tdata
//  dout_valid       out  1            = core_m_tvalid
//  dout_ready       in   1            downstream ready
//  dout_last        out  1            out_cnt == N-1
//  dout_bin         out  MAX_LOG2N    bin index (out_cnt)
//  frame_count      out  16           input frames completed, wraps
//  err_count        out  ERR_W        framing errors, saturating
//  busy             out  1            state != RUN
// BEHAVIOUR
//  - States: LOAD -> SEND -> RUN -> DRAIN -> LOAD. Reset enters LOAD.
//  - LOAD (1 cycle): act_log2n <= clamp(cfg_log2n), act_inv <= cfg_inverse; N = 2**act_log2n.
//  - SEND: core_cfg_tvalid=1 (registered), held until core_cfg_tready; then RUN.
//  - RUN: din_ready = core_s_tready; in_cnt++ on din handshake; core_s_tlast = (in_cnt==N-1);
//    in_cnt wraps to 0 after last; frame_count++ on last handshake.
//  - Change detect: (clamp(cfg_log2n),cfg_inverse) != active while in_cnt==0 and no din
//    handshake that cycle -> DRAIN. Mid-frame changes deferred to next boundary.
//  - DRAIN: din_ready=0, core_s_tvalid=0; when in_flight==0 -> LOAD.
//  - in_flight: +1 on input-last handshake, -1 on dout_last handshake; both same cycle -> unchanged.
//  - Data paths are combinational, zero latency; din_ready=0 and core_s_tvalid=0 outside RUN.
//  - Output: out_cnt++ on dout handshake, wraps at N-1. If core_m_tlast != dout_last on a
//    handshake: err_count++ and out_cnt <= 0 (resync to core). core_ev_err high: err_count++
//    (one per cycle; coincident with mismatch counts once). err_count saturates at all-ones.
//  - Reset values: core_cfg_tvalid 0, din_ready/core_s_tvalid 0, in_cnt/out_cnt/in_flight 0,
//    frame_count 0, err_count 0, busy 1, dout_last 0 only if N>1 (always true, N>=8).
//  - Reset mid-frame: counters cleared, config resent; core must be reset alongside.
// TESTING
//  1. Reset, cfg_log2n=10, fwd; core_cfg_tready=1 -> cfg_tdata[4:0]=10, [8]=1 at cycle 2;
//     1024 samples -> core_s_tlast only on sample 1023; frame_count=1.
//  2. Random din_valid/core_s_tready gaps (30%) -> tlast still exactly every 1024th handshake.
//  3. cfg_log2n 10->6 at sample 500 -> frame completes at 1024, DRAIN until output frame
//     drained, new config log2n=6, next tlast after 64 samples.
//  4. cfg_log2n=2 and 15 -> clamped to 3 and 10; dout_last every 8 / 1024 bins.
//  5. Core m_tlast injected at bin 100 -> err_count=1, dout_bin=0 on next beat; 300 events
//     -> err_count saturates at 255.
//  6. dout_ready backpressure -> core_m_tready follows, dout_bin holds.

Source files
------------

// File: rtl/fft_frame_ctrl.sv
// ----------------------------------------------------------------------------
// fft_frame_ctrl
//
// Framing and run-time configuration controller for a streaming xfft core in
// the audio analysis path. Real samples are forwarded to the core as
// {zero imag, real}. The controller counts accepted samples to generate the
// input tlast and counts accepted output beats to generate the bin index and
// the output last flag. Length/direction changes take effect only at a frame
// boundary once every frame already in the core has drained. The controller
// also counts framing errors, and that count saturates.
//
// Ports
//   clk, reset                       clock, synchronous active-high reset
//   cfg_log2n, cfg_inverse           requested length exponent / direction
//   din_*                            real sample stream from the audio side
//   core_s_*                         core data-in channel (AXIS master)
//   core_cfg_*                       core config channel (AXIS master)
//   core_m_*                         core data-out channel (AXIS slave)
//   core_ev_err                      core tlast_unexpected | tlast_missing
//   dout_*                           output bins to downstream, with index
//   frame_count                      completed input frames (wraps)
//   err_count                        framing errors (saturating)
//   busy                             high whenever not streaming (state != RUN)
// ----------------------------------------------------------------------------
module fft_frame_ctrl #(
    parameter int                    DATA_W    = 24,
    parameter int                    MAX_LOG2N = 10,
    parameter logic [MAX_LOG2N-1:0]  SCALE_SCH = 10'b1010101011,
    parameter int                    ERR_W     = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [3:0]              cfg_log2n,
    input  logic                    cfg_inverse,
    input  logic [DATA_W-1:0]       din_data,
    input  logic                    din_valid,
    output logic                    din_ready,
    output logic [2*DATA_W-1:0]     core_s_tdata,
    output logic                    core_s_tvalid,
    input  logic                    core_s_tready,
    output logic                    core_s_tlast,
    output logic [23:0]             core_cfg_tdata,
    output logic                    core_cfg_tvalid,
    input  logic                    core_cfg_tready,
    input  logic [2*DATA_W-1:0]     core_m_tdata,
    input  logic                    core_m_tvalid,
    input  logic                    core_m_tlast,
    output logic                    core_m_tready,
    input  logic                    core_ev_err,
    output logic [2*DATA_W-1:0]     dout_data,
    output logic                    dout_valid,
    input  logic                    dout_ready,
    output logic                    dout_last,
    output logic [MAX_LOG2N-1:0]    dout_bin,
    output logic [15:0]             frame_count,
    output logic [ERR_W-1:0]        err_count,
    output logic                    busy
);

    localparam logic [1:0] S_LOAD  = 2'd0;
    localparam logic [1:0] S_SEND  = 2'd1;
    localparam logic [1:0] S_RUN   = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    localparam logic [3:0]           LOG2N_MIN = 4'd3;
    localparam logic [3:0]           LOG2N_MAX = 4'(MAX_LOG2N);
    localparam logic [MAX_LOG2N-1:0] CNT_ONE   = {{(MAX_LOG2N-1){1'b0}}, 1'b1};
    localparam logic [ERR_W-1:0]     ERR_ONE   = {{(ERR_W-1){1'b0}}, 1'b1};
    localparam logic [3:0]           FLT_ONE   = 4'd1;

    logic [1:0]            r_state;
    logic [3:0]            r_act_log2n;
    logic                  r_act_inv;
    logic                  r_cfg_valid;
    logic [MAX_LOG2N-1:0]  r_in_cnt;
    logic [MAX_LOG2N-1:0]  r_out_cnt;
    logic [3:0]            r_in_flight;
    logic [15:0]           r_frame_count;
    logic [ERR_W-1:0]      r_err_count;

    logic                  w_run;
    logic [3:0]            w_clamp;
    logic                  w_change;
    logic [MAX_LOG2N-1:0]  w_nm1;
    logic                  w_in_hs;
    logic                  w_in_last;
    logic                  w_out_hs;
    logic                  w_out_last;
    logic                  w_mismatch;
    logic                  w_err_evt;
    logic [23:0]           w_cfg_tdata;

    // Clamp the requested exponent into the range the core supports.
    always_comb begin
        w_clamp = cfg_log2n;
        if (cfg_log2n < LOG2N_MIN)
            w_clamp = LOG2N_MIN;
        else if (cfg_log2n > LOG2N_MAX)
            w_clamp = LOG2N_MAX;
    end

    // N-1 as a mask of act_log2n ones; shifting an all-ones word keeps it
    // MAX_LOG2N bits wide even for the full-length case.
    assign w_nm1 = ~({MAX_LOG2N{1'b1}} << r_act_log2n);

    assign w_run      = (r_state == S_RUN);
    assign w_change   = (w_clamp != r_act_log2n) || (cfg_inverse != r_act_inv);
    assign w_in_hs    = w_run && din_valid && core_s_tready;
    assign w_in_last  = (r_in_cnt == w_nm1);
    assign w_out_hs   = core_m_tvalid && dout_ready;
    assign w_out_last = (r_out_cnt == w_nm1);
    assign w_mismatch = w_out_hs && (core_m_tlast != w_out_last);
    assign w_err_evt  = w_mismatch || core_ev_err;

    always_comb begin
        w_cfg_tdata                  = '0;
        w_cfg_tdata[4:0]             = {1'b0, r_act_log2n};
        w_cfg_tdata[8]               = ~r_act_inv;
        w_cfg_tdata[8+MAX_LOG2N:9]   = SCALE_SCH;
    end

    // Frame/config state machine.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_LOAD;
            r_act_log2n <= LOG2N_MAX;
            r_act_inv   <= 1'b0;
            r_cfg_valid <= 1'b0;
        end else begin
            case (r_state)
                S_LOAD: begin
                    r_act_log2n <= w_clamp;
                    r_act_inv   <= cfg_inverse;
                    r_cfg_valid <= 1'b1;
                    r_state     <= S_SEND;
                end
                S_SEND: begin
                    if (core_cfg_tready) begin
                        r_cfg_valid <= 1'b0;
                        r_state     <= S_RUN;
                    end
                end
                S_RUN: begin
                    // Only a clean boundary (nothing accepted this cycle)
                    // may start a reconfiguration.
                    if ((r_in_cnt == '0) && !w_in_hs && w_change)
                        r_state <= S_DRAIN;
                end
                default: begin
                    if (r_in_flight == '0)
                        r_state <= S_LOAD;
                end
            endcase
        end
    end

    // Input sample counter and completed-frame counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_in_cnt      <= '0;
            r_frame_count <= '0;
        end else if (w_in_hs) begin
            if (w_in_last) begin
                r_in_cnt      <= '0;
                r_frame_count <= r_frame_count + 16'd1;
            end else begin
                r_in_cnt <= r_in_cnt + CNT_ONE;
            end
        end
    end

    // Frames inside the core: entered on input last, left on output last.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_in_flight <= '0;
        end else begin
            case ({w_in_hs && w_in_last, w_out_hs && w_out_last})
                2'b10:   r_in_flight <= r_in_flight + FLT_ONE;
                2'b01:   if (r_in_flight != '0) r_in_flight <= r_in_flight - FLT_ONE;
                default: r_in_flight <= r_in_flight;
            endcase
        end
    end

    // Output bin counter; a last-flag disagreement with the core realigns
    // the count to the core's framing.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_cnt <= '0;
        end else if (w_out_hs) begin
            if (w_mismatch || w_out_last)
                r_out_cnt <= '0;
            else
                r_out_cnt <= r_out_cnt + CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            r_err_count <= '0;
        else if (w_err_evt && (r_err_count != '1))
            r_err_count <= r_err_count + ERR_ONE;
    end

    assign din_ready       = w_run && core_s_tready;
    assign core_s_tvalid   = w_run && din_valid;
    assign core_s_tdata    = {{DATA_W{1'b0}}, din_data};
    assign core_s_tlast    = w_in_last;
    assign core_cfg_tdata  = w_cfg_tdata;
    assign core_cfg_tvalid = r_cfg_valid;
    assign core_m_tready   = dout_ready;
    assign dout_data       = core_m_tdata;
    assign dout_valid      = core_m_tvalid;
    assign dout_last       = w_out_last;
    assign dout_bin        = r_out_cnt;
    assign frame_count     = r_frame_count;
    assign err_count       = r_err_count;
    assign busy            = !w_run;

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// ----------------------------------------------------------------------------
// tb_fft_frame_ctrl
//
// Directed bench for fft_frame_ctrl: config handshake and encoding, input
// tlast placement with and without flow-control gaps, deferred reconfiguration
// with drain, length clamping, output bin/last generation, resync on a core
// last disagreement, error saturation and output backpressure.
// ----------------------------------------------------------------------------
module tb_fft_frame_ctrl;

    localparam int DW = 24;
    localparam int ML = 10;
    localparam int EW = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic [3:0]        cfg_log2n;
    logic              cfg_inverse;
    logic [DW-1:0]     din_data;
    logic              din_valid;
    logic              din_ready;
    logic [2*DW-1:0]   core_s_tdata;
    logic              core_s_tvalid;
    logic              core_s_tready;
    logic              core_s_tlast;
    logic [23:0]       core_cfg_tdata;
    logic              core_cfg_tvalid;
    logic              core_cfg_tready;
    logic [2*DW-1:0]   core_m_tdata;
    logic              core_m_tvalid;
    logic              core_m_tlast;
    logic              core_m_tready;
    logic              core_ev_err;
    logic [2*DW-1:0]   dout_data;
    logic              dout_valid;
    logic              dout_ready;
    logic              dout_last;
    logic [ML-1:0]     dout_bin;
    logic [15:0]       frame_count;
    logic [EW-1:0]     err_count;
    logic              busy;

    int n_tests    = 0;
    int n_fail     = 0;
    int ebin       = 0;
    int exp_err    = 0;
    int exp_frames = 0;

    always #5 clk = ~clk;

    fft_frame_ctrl #(
        .DATA_W    (DW),
        .MAX_LOG2N (ML),
        .SCALE_SCH (10'b1010101011),
        .ERR_W     (EW)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .cfg_log2n       (cfg_log2n),
        .cfg_inverse     (cfg_inverse),
        .din_data        (din_data),
        .din_valid       (din_valid),
        .din_ready       (din_ready),
        .core_s_tdata    (core_s_tdata),
        .core_s_tvalid   (core_s_tvalid),
        .core_s_tready   (core_s_tready),
        .core_s_tlast    (core_s_tlast),
        .core_cfg_tdata  (core_cfg_tdata),
        .core_cfg_tvalid (core_cfg_tvalid),
        .core_cfg_tready (core_cfg_tready),
        .core_m_tdata    (core_m_tdata),
        .core_m_tvalid   (core_m_tvalid),
        .core_m_tlast    (core_m_tlast),
        .core_m_tready   (core_m_tready),
        .core_ev_err     (core_ev_err),
        .dout_data       (dout_data),
        .dout_valid      (dout_valid),
        .dout_ready      (dout_ready),
        .dout_last       (dout_last),
        .dout_bin        (dout_bin),
        .frame_count     (frame_count),
        .err_count       (err_count),
        .busy            (busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Feed n accepted samples; optionally change cfg_log2n after change_at.
    task automatic in_frame(input int n, input bit gaps, input int change_at,
                            input logic [3:0] new_log2n);
        int hs = 0;
        int cyc = 0;
        int tl_bad = 0;
        int if_bad = 0;
        while (hs < n && cyc < 8 * n + 100) begin
            din_valid     = gaps ? ((cyc % 7) != 3) : 1'b1;
            core_s_tready = gaps ? ((cyc % 5) != 1) : 1'b1;
            din_data      = DW'($urandom);
            #1;
            if (busy !== 1'b0 || din_ready !== core_s_tready ||
                core_s_tvalid !== din_valid ||
                core_s_tdata !== {{DW{1'b0}}, din_data})
                if_bad++;
            if (din_valid && din_ready) begin
                if (core_s_tlast !== (hs == n - 1)) tl_bad++;
                hs++;
                if (hs == n) exp_frames++;
                if (hs == change_at) cfg_log2n = new_log2n;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        din_valid     = 1'b0;
        core_s_tready = 1'b1;
        chk("in_handshakes", hs, n);
        chk("in_tlast_pos", tl_bad, 0);
        chk("in_interface", if_bad, 0);
        chk("frame_count", frame_count, exp_frames);
    endtask

    // Drive nb output beats of an nlen-point frame; beat inj carries a
    // spurious core last. Optional downstream backpressure.
    task automatic out_frame(input int nb, input int nlen, input int inj, input bit bp);
        int k = 0;
        int cyc = 0;
        int bad = 0;
        logic exp_last;
        logic mt;
        while (k < nb && cyc < 4 * nb + 100) begin
            dout_ready    = bp ? ((cyc % 3) != 0) : 1'b1;
            core_m_tvalid = 1'b1;
            core_m_tdata  = (2*DW)'({$urandom, $urandom});
            exp_last      = (ebin == nlen - 1);
            mt            = (k == inj) ? 1'b1 : exp_last;
            core_m_tlast  = mt;
            #1;
            if (core_m_tready !== dout_ready || dout_valid !== 1'b1 ||
                dout_data !== core_m_tdata || dout_bin !== ML'(ebin) ||
                dout_last !== exp_last)
                bad++;
            if (dout_ready) begin
                if (mt != exp_last) begin
                    ebin = 0;
                    exp_err++;
                end else begin
                    ebin = exp_last ? 0 : ebin + 1;
                end
                k++;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        core_m_tvalid = 1'b0;
        core_m_tlast  = 1'b0;
        dout_ready    = 1'b1;
        chk("out_beats", k, nb);
        chk("out_beat_checks", bad, 0);
        chk("err_count", err_count, exp_err);
    endtask

    task automatic wait_cfg(input logic [3:0] el, input logic inv);
        int c = 0;
        while (core_cfg_tvalid !== 1'b1 && c < 20) begin
            tick();
            c++;
        end
        chk("cfg_valid_seen", core_cfg_tvalid, 1);
        chk("cfg_tdata", core_cfg_tdata,
            {5'b0, 10'b1010101011, ~inv, 3'b0, 1'b0, el});
        chk("busy_send", busy, 1);
        tick();
        chk("cfg_valid_drop", core_cfg_tvalid, 0);
        chk("busy_run", busy, 0);
    endtask

    initial begin
        #5000000;
        $display("FAIL timeout: simulation did not reach its end");
        $fatal(1, "timeout");
    end

    initial begin
        reset           = 1'b1;
        cfg_log2n       = 4'd10;
        cfg_inverse     = 1'b0;
        din_valid       = 1'b1;
        din_data        = 24'h123456;
        core_s_tready   = 1'b1;
        core_cfg_tready = 1'b0;
        core_m_tvalid   = 1'b0;
        core_m_tlast    = 1'b0;
        core_m_tdata    = '0;
        core_ev_err     = 1'b0;
        dout_ready      = 1'b1;
        repeat (3) tick();

        // Reset state
        chk("rst_busy", busy, 1);
        chk("rst_cfg_valid", core_cfg_tvalid, 0);
        chk("rst_din_ready", din_ready, 0);
        chk("rst_s_tvalid", core_s_tvalid, 0);
        chk("rst_frame_count", frame_count, 0);
        chk("rst_err_count", err_count, 0);
        chk("rst_dout_bin", dout_bin, 0);
        chk("rst_dout_last", dout_last, 0);

        // Initial config: forward, 1024 points, held until ready
        din_valid = 1'b0;
        reset     = 1'b0;
        tick();
        chk("cfg1_valid", core_cfg_tvalid, 1);
        chk("cfg1_tdata", core_cfg_tdata, 24'h05570A);
        tick();
        chk("cfg1_held", core_cfg_tvalid, 1);
        chk("cfg1_busy", busy, 1);
        core_cfg_tready = 1'b1;
        tick();
        chk("cfg1_done", core_cfg_tvalid, 0);
        chk("run_busy", busy, 0);

        // Frame 1 clean, frame 2 with gaps and output backpressure
        in_frame(1024, 1'b0, -1, 4'd0);
        out_frame(1024, 1024, -1, 1'b0);
        in_frame(1024, 1'b1, -1, 4'd0);
        out_frame(1024, 1024, -1, 1'b1);

        // Length change mid-frame: deferred, then drain before reconfig
        in_frame(1024, 1'b0, 500, 4'd6);
        tick();
        chk("drain_busy", busy, 1);
        din_valid = 1'b1;
        #1;
        chk("drain_din_ready", din_ready, 0);
        chk("drain_s_tvalid", core_s_tvalid, 0);
        chk("drain_no_cfg", core_cfg_tvalid, 0);
        din_valid = 1'b0;
        out_frame(1024, 1024, -1, 1'b0);
        wait_cfg(4'd6, 1'b0);
        in_frame(64, 1'b1, -1, 4'd0);
        out_frame(64, 64, -1, 1'b0);

        // Clamping: 2 -> 3, 15 -> 10 with inverse
        cfg_log2n = 4'd2;
        wait_cfg(4'd3, 1'b0);
        in_frame(8, 1'b1, -1, 4'd0);
        in_frame(8, 1'b0, -1, 4'd0);
        out_frame(16, 8, -1, 1'b0);
        cfg_log2n   = 4'd15;
        cfg_inverse = 1'b1;
        wait_cfg(4'd10, 1'b1);
        in_frame(1024, 1'b0, -1, 4'd0);

        // Spurious core last at bin 100 -> resync
        out_frame(101, 1024, 100, 1'b0);
        chk("err_after_inject", err_count, 1);
        core_m_tvalid = 1'b1;
        core_m_tlast  = 1'b0;
        dout_ready    = 1'b0;
        #1;
        chk("bin_after_resync", dout_bin, 0);
        chk("m_tready_follows", core_m_tready, 0);
        dout_ready = 1'b1;
        out_frame(1024, 1024, -1, 1'b0);

        // Error events saturate
        core_ev_err = 1'b1;
        repeat (253) tick();
        chk("err_254", err_count, 254);
        repeat (47) tick();
        chk("err_sat", err_count, 255);
        core_ev_err = 1'b0;
        tick();
        chk("err_sat_hold", err_count, 255);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
